// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between the producers, the arbiter and the shared FIFO.
// Zero latency: pure wiring, no storage.
// Backpressure: fifo_full from the FIFO gates every ack issued by the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int N    = 8,
  parameter int REQS = 4
);
  localparam int SW = $clog2(REQS);

  logic [REQS-1:0]        req;
  logic [REQS-1:0][N-1:0] data;
  logic [REQS-1:0]        ack;
  logic                   fifo_full;
  logic                   fifo_wrreq;
  logic [N-1:0]           fifo_in;
  logic [SW-1:0]          fifo_src;
  logic                   busy;

  // Producer/FIFO side: offers words and reports FIFO fullness.
  modport master (
    output req, data, fifo_full,
    input  ack, fifo_wrreq, fifo_in, fifo_src, busy
  );

  // Arbiter side.
  modport slave (
    input  req, data, fifo_full,
    output ack, fifo_wrreq, fifo_in, fifo_src, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among REQS producers, bursts up to BURST words.
// Zero-cycle accept: ack and fifo_wrreq are combinational, word lands on the ack edge.
// Backpressure: no ack while fifo_full; an owner keeps its grant across a full stall.
module fifo_wr_arbiter #(
  parameter int N     = 8,
  parameter int REQS  = 4,
  parameter int BURST = 4
) (
  input logic              clk,
  input logic              reset,
  fifo_wr_arbiter_if.slave bus
);
  localparam int SW = $clog2(REQS);
  localparam int CW = $clog2(BURST + 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] owner_q, owner_d;
  logic [SW-1:0] ptr_q,   ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [SW-1:0]   cand;
  logic            cand_vld;
  logic            own_hold;
  logic [SW-1:0]   scan_idx;
  logic [REQS-1:0] ack_c;
  logic            xfer;
  logic [CW-1:0]   cnt_next;

  // Index increment that wraps at REQS, also for non-power-of-two REQS.
  function automatic logic [SW-1:0] next_idx(input logic [SW-1:0] i);
    if (i == SW'(REQS - 1)) return '0;
    return i + SW'(1);
  endfunction

  // Candidate selection: the live owner wins, otherwise a rotating scan; drives ack and the FIFO port.
  always_comb begin
    own_hold = (state_q == OWN) && bus.req[owner_q];
    cand     = '0;
    cand_vld = 1'b0;
    // After a release the scan starts just past the departing owner.
    scan_idx = (state_q == OWN) ? next_idx(owner_q) : ptr_q;
    if (own_hold) begin
      cand     = owner_q;
      cand_vld = 1'b1;
    end else begin
      for (int k = 0; k < REQS; k++) begin
        if (!cand_vld && bus.req[scan_idx]) begin
          cand     = scan_idx;
          cand_vld = 1'b1;
        end
        scan_idx = next_idx(scan_idx);
      end
    end

    ack_c = '0;
    if (cand_vld && !bus.fifo_full && !reset) ack_c[cand] = 1'b1;
    xfer = |(bus.req & ack_c);
  end

  assign bus.ack        = ack_c;
  assign bus.fifo_wrreq = xfer;
  assign bus.fifo_in    = xfer ? bus.data[cand] : '0;
  assign bus.fifo_src   = xfer ? cand : '0;
  assign bus.busy       = (state_q == OWN);

  // Grant/burst bookkeeping: start or extend a burst on transfer, rotate on burst end or release.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    count_d  = count_q;
    cnt_next = count_q;
    if (xfer) begin
      if (own_hold) begin
        cnt_next = count_q + CW'(1);
      end else begin
        owner_d  = cand;
        cnt_next = CW'(1);
        state_d  = OWN;
      end
      count_d = cnt_next;
      if (cnt_next == CW'(BURST)) begin
        state_d = IDLE;
        ptr_d   = next_idx(cand);
        count_d = '0;
      end
    end else if ((state_q == OWN) && !bus.req[owner_q]) begin
      // Owner went away without a replacement transfer (e.g. during a full stall).
      state_d = IDLE;
      ptr_d   = next_idx(owner_q);
      count_d = '0;
    end
  end

  // State registers with synchronous reset; a reset abandons any burst in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench: a cycle table for REQS=4/BURST=4 plus a per-word rotation sequence for REQS=3/BURST=1.
// Inputs change on the falling edge, outputs are compared 2 time units later, before the next rising edge.
// The FIFO is represented only by the fifo_full input driven from the table.
module tb_fifo_wr_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.N(8), .REQS(4)) if_a ();
  fifo_wr_arbiter_if #(.N(8), .REQS(3)) if_b ();

  fifo_wr_arbiter #(.N(8), .REQS(4), .BURST(4)) dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
  fifo_wr_arbiter #(.N(8), .REQS(3), .BURST(1)) dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] dat;
    logic        full;
    logic [3:0]  ack;
    logic        wr;
    logic [7:0]  din;
    logic [1:0]  src;
    logic        busy;
  } vec_t;

  localparam int NV = 48;
  localparam logic [31:0] DALL = 32'h44332211;
  vec_t tv [NV];

  function automatic vec_t mk(input logic rst, input logic [3:0] req, input logic [31:0] dat,
                              input logic full, input logic [3:0] ack, input logic wr,
                              input logic [7:0] din, input logic [1:0] src, input logic busy);
    vec_t v;
    v.rst = rst; v.req = req; v.dat = dat; v.full = full;
    v.ack = ack; v.wr = wr; v.din = din; v.src = src; v.busy = busy;
    return v;
  endfunction

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  initial begin
    // Single requester: burst of 4, one-cycle IDLE regrant, then release.
    tv[0] = mk(0, 4'b0000, 32'h00, 0, 4'b0000, 0, 8'h00, 0, 0);
    tv[1] = mk(0, 4'b0001, 32'h11, 0, 4'b0001, 1, 8'h11, 0, 0);
    tv[2] = mk(0, 4'b0001, 32'h12, 0, 4'b0001, 1, 8'h12, 0, 1);
    tv[3] = mk(0, 4'b0001, 32'h13, 0, 4'b0001, 1, 8'h13, 0, 1);
    tv[4] = mk(0, 4'b0001, 32'h14, 0, 4'b0001, 1, 8'h14, 0, 1);
    tv[5] = mk(0, 4'b0001, 32'h15, 0, 4'b0001, 1, 8'h15, 0, 0);
    tv[6] = mk(0, 4'b0001, 32'h16, 0, 4'b0001, 1, 8'h16, 0, 1);
    tv[7] = mk(0, 4'b0000, 32'h00, 0, 4'b0000, 0, 8'h00, 0, 1);
    tv[8] = mk(0, 4'b0000, 32'h00, 0, 4'b0000, 0, 8'h00, 0, 0);
    // Reset with requests pending, then all four requesting: 0x4, 1x4, 2x4, 3x4, 0.
    tv[9]  = mk(1, 4'b1111, DALL, 0, 4'b0000, 0, 8'h00, 0, 0);
    tv[10] = mk(0, 4'b1111, DALL, 0, 4'b0001, 1, 8'h11, 0, 0);
    for (int i = 11; i <= 13; i++) tv[i] = mk(0, 4'b1111, DALL, 0, 4'b0001, 1, 8'h11, 0, 1);
    tv[14] = mk(0, 4'b1111, DALL, 0, 4'b0010, 1, 8'h22, 1, 0);
    for (int i = 15; i <= 17; i++) tv[i] = mk(0, 4'b1111, DALL, 0, 4'b0010, 1, 8'h22, 1, 1);
    tv[18] = mk(0, 4'b1111, DALL, 0, 4'b0100, 1, 8'h33, 2, 0);
    for (int i = 19; i <= 21; i++) tv[i] = mk(0, 4'b1111, DALL, 0, 4'b0100, 1, 8'h33, 2, 1);
    tv[22] = mk(0, 4'b1111, DALL, 0, 4'b1000, 1, 8'h44, 3, 0);
    for (int i = 23; i <= 25; i++) tv[i] = mk(0, 4'b1111, DALL, 0, 4'b1000, 1, 8'h44, 3, 1);
    tv[26] = mk(0, 4'b1111, DALL, 0, 4'b0001, 1, 8'h11, 0, 0);
    // Early release: owner 0 takes a 2nd word, drops; 2 is granted in the same cycle, ptr ends at 3.
    tv[27] = mk(0, 4'b0101, DALL, 0, 4'b0001, 1, 8'h11, 0, 1);
    for (int i = 28; i <= 31; i++) tv[i] = mk(0, 4'b0100, DALL, 0, 4'b0100, 1, 8'h33, 2, 1);
    tv[32] = mk(0, 4'b1111, DALL, 0, 4'b1000, 1, 8'h44, 3, 0);
    // Owner 3 drops, 1 takes over and reaches count 2, then a 3-cycle full stall.
    tv[33] = mk(0, 4'b0010, DALL, 0, 4'b0010, 1, 8'h22, 1, 1);
    tv[34] = mk(0, 4'b1111, DALL, 0, 4'b0010, 1, 8'h22, 1, 1);
    for (int i = 35; i <= 37; i++) tv[i] = mk(0, 4'b1111, DALL, 1, 4'b0000, 0, 8'h00, 0, 1);
    for (int i = 38; i <= 39; i++) tv[i] = mk(0, 4'b1111, DALL, 0, 4'b0010, 1, 8'h22, 1, 1);
    tv[40] = mk(0, 4'b1111, DALL, 0, 4'b0100, 1, 8'h33, 2, 0);
    for (int i = 41; i <= 42; i++) tv[i] = mk(0, 4'b1111, DALL, 0, 4'b0100, 1, 8'h33, 2, 1);
    // Reset at owner 2, count 3; restart from requester 0.
    tv[43] = mk(1, 4'b1111, DALL, 0, 4'b0000, 0, 8'h00, 0, 1);
    tv[44] = mk(0, 4'b1111, DALL, 0, 4'b0001, 1, 8'h11, 0, 0);
    // Owner drops during a stall: release, next grant scans from 1.
    tv[45] = mk(0, 4'b1111, DALL, 1, 4'b0000, 0, 8'h00, 0, 1);
    tv[46] = mk(0, 4'b1110, DALL, 1, 4'b0000, 0, 8'h00, 0, 1);
    tv[47] = mk(0, 4'b1110, DALL, 0, 4'b0010, 1, 8'h22, 1, 0);

    reset = 1'b1;
    if_a.req = '0; if_a.data = '0; if_a.fifo_full = 1'b0;
    if_b.req = '0; if_b.data = '0; if_b.fifo_full = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      reset          = tv[i].rst;
      if_a.req       = tv[i].req;
      if_a.data      = tv[i].dat;
      if_a.fifo_full = tv[i].full;
      #2;
      check("ack",   i, 32'(if_a.ack),        32'(tv[i].ack));
      check("wrreq", i, 32'(if_a.fifo_wrreq), 32'(tv[i].wr));
      check("in",    i, 32'(if_a.fifo_in),    32'(tv[i].din));
      check("src",   i, 32'(if_a.fifo_src),   32'(tv[i].src));
      check("busy",  i, 32'(if_a.busy),       32'(tv[i].busy));
      @(negedge clk);
    end
    if_a.req = '0;

    // BURST=1, REQS=3: pure per-word rotation with wrap from 2 back to 0.
    begin
      logic [1:0] g111 [6];
      logic [1:0] g101 [4];
      logic [7:0] w [3];
      g111 = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
      g101 = '{2'd0, 2'd2, 2'd0, 2'd2};
      w    = '{8'hA0, 8'hB1, 8'hC2};

      reset = 1'b1;
      if_b.data = {w[2], w[1], w[0]};
      if_b.req  = 3'b111;
      #2;
      check("b_rst_ack", 0, 32'(if_b.ack), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
        #2;
        check("b111_ack",  i, 32'(if_b.ack),      32'(3'b001 << g111[i]));
        check("b111_in",   i, 32'(if_b.fifo_in),  32'(w[g111[i]]));
        check("b111_src",  i, 32'(if_b.fifo_src), 32'(g111[i]));
        check("b111_busy", i, 32'(if_b.busy),     32'd0);
        @(negedge clk);
      end
      if_b.req = 3'b101;
      for (int i = 0; i < 4; i++) begin
        #2;
        check("b101_ack", i, 32'(if_b.ack),      32'(3'b001 << g101[i]));
        check("b101_src", i, 32'(if_b.fifo_src), 32'(g101[i]));
        check("b101_wr",  i, 32'(if_b.fifo_wrreq), 32'd1);
        @(negedge clk);
      end
      if_b.req = '0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares a single `fifo_sync` write port among several producers, e.g. APU/PPU/CPU-side event sources pushing into one shared queue. It picks one requester per cycle and drives the FIFO's `wrreq`/`in` combinationally. Each grant can hold the port for a bounded burst of back-to-back words. Writes are never issued while the FIFO is full, so `overrun` on the FIFO can never fire.

## Interface
- `N`, 8, data word width (matches the FIFO `N`)
- `REQS`, 4, number of requesters (≥2)
- `BURST`, 4, maximum consecutive words per grant (≥1); counter width `$clog2(BURST+1)`
- `SW`, `$clog2(REQS)`, source-index width (derived, not overridable)

Ports:
- `clk`  in  1  rising-edge clock; single clock domain
- `reset`  in  1  synchronous, active-high reset
- `req`  in  REQS  per-requester valid; bit i means `data[i]` is offered
- `data`  in  REQS×N (packed `[REQS-1:0][N-1:0]`)  per-requester word
- `ack`  out  REQS  one-hot or zero; word i transfers on the edge where `req[i] & ack[i]`
- `fifo_full`  in  1  FIFO `full` output
- `fifo_wrreq`  out  1  to FIFO `wrreq`
- `fifo_in`  out  N  to FIFO `in`
- `fifo_src`  out  SW  index of the requester being written (valid when `fifo_wrreq`)
- `busy`  out  1  arbiter currently in OWN state

## Operation
- Registered state:
  - `state` ∈ {IDLE, OWN}
  - `owner` (SW bits)
  - `ptr` (SW bits, round-robin start)
  - `count` (burst words taken by owner)
- Candidate selection (combinational):
  - OWN with `req[owner]`=1: the candidate is `owner`.
  - Otherwise (IDLE, or OWN with `req[owner]`=0): the candidate is the first set `req` bit scanning `ptr, ptr+1, …` modulo REQS. In the OWN-released case the scan starts at `owner+1` mod REQS.
- Grant: `ack[c]` = `req[c] & ~fifo_full & ~reset` for candidate c. All other `ack` bits are 0.
- FIFO drive:
  - `fifo_wrreq` = `|(req & ack)`
  - `fifo_in` = `data[c]`, `fifo_src` = c
  - When `fifo_wrreq`=0, `fifo_in` and `fifo_src` are don't-care; drive 0.
- State update on each transfer from c:
  - New grant (from IDLE, or after release): `owner`←c, `count`←1, state←OWN.
  - Continued burst: `count`←`count+1`.
  - If the new count equals BURST: state←IDLE, `ptr`←c+1 mod REQS, `count`←0.
  - BURST=1 therefore degenerates to pure per-word round-robin.
- Owner release: in OWN with `req[owner]`=0 and no transfer this cycle: state←IDLE, `ptr`←`owner+1`, `count`←0.
- Full stall:
  - `fifo_full`=1 gives no transfer. State, `owner`, `count` and `ptr` are all held; an owner keeps its grant across the stall.
  - Exception: if the owner's `req` also dropped during the stall, the release rule applies.
- No transfer in IDLE: hold everything.
- `busy` = (state == OWN).

## Timing
- Zero-cycle accept latency. The word is written into the FIFO on the same edge it is acked. The FIFO's `out` shows it from the next cycle if the FIFO was empty.
- Requesters must hold `req`/`data` stable until they see `ack`. They may change `data` in the cycle after the ack edge for the next word, which allows back-to-back bursts with no bubble.
- Release and regrant happen in the same cycle, so there is no idle cycle between owners.
- Full boundary:
  - `fifo_full` is registered in the FIFO and updates on the write that fills it.
  - The arbiter never writes while `fifo_full`=1.
  - A simultaneous FIFO read and arbiter write in the full cycle is not performed; the write waits one cycle.
- Reset (any cycle, including mid-burst):
  - `ack`=0 and `fifo_wrreq`=0 during the reset cycle.
  - After the edge: state=IDLE, `owner`=0, `ptr`=0, `count`=0, `busy`=0.
  - The partially sent burst is abandoned; words already transferred remain the FIFO's responsibility.
- Pointer wrap: `owner+1` and `ptr+1` wrap modulo REQS, including for non-power-of-two REQS. For example REQS=3: index 2 wraps to 0.

## Test plan
- Single requester: `req`=0001, words 0x11..0x16, BURST=4, FIFO never full.
  - `ack[0]` high for 4 consecutive cycles; `busy` drops for one grant cycle, then `ack[0]` resumes (regrant, since no other requester).
  - FIFO receives 0x11..0x16 in order, `fifo_src`=0.
- All four requesting continuously, BURST=4:
  - Grant order 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0,…
  - One write per cycle, no bubbles.
- Early release: req0 holds 2 words then drops, with req2 pending.
  - Next cycle grants 2 (scan from 1) with no idle cycle; `ptr` ends at 3 after req2's burst.
- Full stall mid-burst: owner 1 at `count`=2, then `fifo_full` asserted for 3 cycles.
  - `ack`=0 and `fifo_wrreq`=0 for those 3 cycles; owner stays 1.
  - After full clears, exactly 2 more words from requester 1, then rotation to 2.
  - FIFO `overrun` never asserts.
- Reset mid-burst at `count`=3, owner 2, all requesting.
  - Reset cycle: `ack`=0.
  - After reset: first grant to requester 0, `busy`=0 before the grant.
- BURST=1, REQS=3, `req`=111:
  - Grants 0,1,2,0,1,2.
  - Then `req`=101 gives grants 0,2,0,2, with correct wrap.
